// File: rtl/packet_checker_pkg.sv
// Shared constants, FSM state type and keep-popcount helper for packet_checker.
package packet_checker_pkg;
    localparam int HDR_BYTES  = 14;
    localparam int LEN_W      = 11;
    localparam int CNT_W      = 32;
    localparam int MAX_KEEP_W = 128;  // tkeep width of the widest supported bus (1024 bits)

    typedef enum logic {S_HEAD = 1'b0, S_BODY = 1'b1} state_t;

    function automatic logic [LEN_W-1:0] popcount_keep(input logic [MAX_KEEP_W-1:0] keep);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) n = n + LEN_W'(keep[i]);
        return n;
    endfunction
endpackage

// File: rtl/packet_checker_if.sv
// AXI-Stream receive bus for packet_checker.
interface packet_checker_if #(
    parameter int DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/packet_checker_flow_counter.sv
// Saturating event counter used for the per-flow and unmatched statistics.
module flow_counter
    import packet_checker_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/packet_checker.sv
// AXI-Stream Ethernet frame checker: classifies frames against a flow table and keeps stats.
// Optional PACKET_CHECKER_BYTE_COUNT_EN adds per-flow 64-bit byte accumulators (stat_bytes).
module packet_checker
    import packet_checker_pkg::*;
#(
    parameter int                    DATA_WIDTH = 512,
    parameter int                    N_FLOWS    = 4,
    parameter logic [11*N_FLOWS-1:0] SIZES      = {4{11'd192}},
    parameter logic [48*N_FLOWS-1:0] D_MACS     = {48'hABCDEF000001, 48'hABCDEF000002,
                                                   48'hABCDEF000003, 48'hABCDEF000004},
    parameter logic [48*N_FLOWS-1:0] S_MACS     = {48'hBEEFBEEF0001, 48'hBEEFBEEF0002,
                                                   48'hBEEFBEEF0003, 48'hBEEFBEEF0004},
    parameter logic [16*N_FLOWS-1:0] ETHERTYPES = {4{16'h0800}},
    parameter logic [8*N_FLOWS-1:0]  PAYLOADS   = {8'hAA, 8'hBB, 8'hCC, 8'hDD},
    localparam int                   FLOW_W     = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    packet_checker_if.slave            s_axis,
    output logic                       result_valid,
    output logic [FLOW_W-1:0]          result_flow,
    output logic                       result_match,
    output logic                       result_ok,
    output logic [LEN_W-1:0]           result_len,
    output logic [CNT_W*N_FLOWS-1:0]   stat_good,
    output logic [CNT_W*N_FLOWS-1:0]   stat_err,
    output logic [CNT_W-1:0]           stat_unmatched
`ifdef PACKET_CHECKER_BYTE_COUNT_EN
    ,output logic [64*N_FLOWS-1:0]     stat_bytes
`endif
);
    localparam int               KEEP_W  = DATA_WIDTH / 8;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t            state, state_nxt;
    logic              tready_q;
    logic              accept;
    logic [LEN_W-1:0]  beat_cnt;
    logic [47:0]       dmac, smac;
    logic [15:0]       etype;
    logic              hit;
    logic [FLOW_W-1:0] hit_idx;
    logic [FLOW_W-1:0] cur_flow;
    logic [7:0]        exp_byte;
    logic              beat_bad;
    logic [LEN_W:0]    len_sum;

    logic              match_q, match_nxt;
    logic [FLOW_W-1:0] flow_q, flow_nxt;
    logic              err_q, err_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic              fin, fin_ok;

    assign s_axis.tready = tready_q;
    assign accept        = s_axis.tvalid & tready_q;
    assign beat_cnt      = popcount_keep(MAX_KEEP_W'(s_axis.tkeep));

    // Header fields are big-endian on the wire: byte 0 is the DMAC MSB.
    always_comb begin
        dmac = '0;
        smac = '0;
        for (int k = 0; k < 6; k++) begin
            dmac = {dmac[39:0], s_axis.tdata[8*k +: 8]};
            smac = {smac[39:0], s_axis.tdata[8*(k+6) +: 8]};
        end
        etype = {s_axis.tdata[8*12 +: 8], s_axis.tdata[8*13 +: 8]};
    end

    // Scan downwards so the lowest matching index wins; short beats cannot carry a header.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_FLOWS - 1; i >= 0; i--) begin
            if (dmac == D_MACS[48*i +: 48] && smac == S_MACS[48*i +: 48] &&
                etype == ETHERTYPES[16*i +: 16]) begin
                hit     = 1'b1;
                hit_idx = FLOW_W'(i);
            end
        end
        if (beat_cnt < LEN_W'(HDR_BYTES)) begin
            hit     = 1'b0;
            hit_idx = '0;
        end
    end

    assign cur_flow = (state == S_HEAD) ? hit_idx : flow_q;
    assign exp_byte = PAYLOADS[8*cur_flow +: 8];

    always_comb begin
        beat_bad = 1'b0;
        for (int k = 0; k < KEEP_W; k++) begin
            if (s_axis.tkeep[k] && (state == S_BODY || k >= HDR_BYTES) &&
                s_axis.tdata[8*k +: 8] != exp_byte)
                beat_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_HEAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        match_nxt = match_q;
        flow_nxt  = flow_q;
        err_nxt   = err_q;
        len_nxt   = len_q;
        fin       = 1'b0;
        len_sum   = {1'b0, len_q} + {1'b0, beat_cnt};
        if (accept) begin
            case (state)
                S_HEAD: begin
                    match_nxt = hit;
                    flow_nxt  = hit_idx;
                    err_nxt   = beat_bad;
                    len_nxt   = beat_cnt;
                    state_nxt = s_axis.tlast ? S_HEAD : S_BODY;
                end
                S_BODY: begin
                    err_nxt   = err_q | beat_bad;
                    len_nxt   = (len_sum > {1'b0, LEN_MAX}) ? LEN_MAX : len_sum[LEN_W-1:0];
                    state_nxt = s_axis.tlast ? S_HEAD : S_BODY;
                end
                default: state_nxt = S_HEAD;
            endcase
            fin = s_axis.tlast;
        end
    end

    assign fin_ok = match_nxt && !err_nxt && (len_nxt == SIZES[LEN_W*flow_nxt +: LEN_W]);

    always_ff @(posedge clk) begin
        if (rst) begin
            tready_q     <= 1'b0;
            match_q      <= 1'b0;
            flow_q       <= '0;
            err_q        <= 1'b0;
            len_q        <= '0;
            result_valid <= 1'b0;
            result_flow  <= '0;
            result_match <= 1'b0;
            result_ok    <= 1'b0;
            result_len   <= '0;
        end else begin
            tready_q     <= 1'b1;
            match_q      <= match_nxt;
            flow_q       <= flow_nxt;
            err_q        <= err_nxt;
            len_q        <= len_nxt;
            result_valid <= fin;
            if (fin) begin
                result_flow  <= flow_nxt;
                result_match <= match_nxt;
                result_ok    <= fin_ok;
                result_len   <= len_nxt;
            end
        end
    end

    // Counters update on the tlast edge, so they move together with result_valid.
    for (genvar i = 0; i < N_FLOWS; i++) begin : g_flow
        logic sel;
        assign sel = fin && match_nxt && (flow_nxt == FLOW_W'(i));

        flow_counter u_good (
            .clk   (clk),
            .rst   (rst),
            .inc   (sel & fin_ok),
            .count (stat_good[CNT_W*i +: CNT_W])
        );
        flow_counter u_err (
            .clk   (clk),
            .rst   (rst),
            .inc   (sel & ~fin_ok),
            .count (stat_err[CNT_W*i +: CNT_W])
        );

`ifdef PACKET_CHECKER_BYTE_COUNT_EN
        logic [63:0] bytes_q;
        always_ff @(posedge clk) begin
            if (rst)      bytes_q <= '0;
            else if (sel) bytes_q <= bytes_q + 64'(len_nxt);
        end
        assign stat_bytes[64*i +: 64] = bytes_q;
`endif
    end

    flow_counter u_unmatched (
        .clk   (clk),
        .rst   (rst),
        .inc   (fin & ~match_nxt),
        .count (stat_unmatched)
    );
endmodule

// File: tb/tb_packet_checker.sv
// Randomized bench for packet_checker with a byte-level frame reference model.
module tb_packet_checker;
    localparam int DW = 512;
    localparam int NB = DW / 8;
    localparam int NF = 4;
    localparam int FW = 2;
    localparam int FRAME_SIZE = 192;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic          match;
        logic          ok;
        logic [FW-1:0] flow;
        logic [10:0]   len;
        logic [31:0]   cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_checker_if #(.DATA_WIDTH(DW)) s_axis ();
    logic              result_valid, result_match, result_ok;
    logic [FW-1:0]     result_flow;
    logic [10:0]       result_len;
    logic [32*NF-1:0]  stat_good, stat_err;
    logic [31:0]       stat_unmatched;
`ifdef PACKET_CHECKER_BYTE_COUNT_EN
    logic [64*NF-1:0]  stat_bytes;
`endif

    packet_checker #(.DATA_WIDTH(DW), .N_FLOWS(NF)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis         (s_axis),
        .result_valid   (result_valid),
        .result_flow    (result_flow),
        .result_match   (result_match),
        .result_ok      (result_ok),
        .result_len     (result_len),
        .stat_good      (stat_good),
        .stat_err       (stat_err),
        .stat_unmatched (stat_unmatched)
`ifdef PACKET_CHECKER_BYTE_COUNT_EN
        ,.stat_bytes    (stat_bytes)
`endif
    );

    int          vectors = 0;
    int          errors  = 0;
    int unsigned cyc     = 0;
    res_t        got_q[$];
    res_t        exp_q[$];
    int unsigned mg[NF];
    int unsigned me[NF];
    int unsigned mu;
    longint unsigned mb[NF];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (result_valid)
            got_q.push_back(res_t'({result_match, result_ok, result_flow, result_len, cyc}));

    // Expected flow table, flow 0 sits in the low bits of each parameter.
    function automatic logic [47:0] tb_dmac(input int f); return 48'hABCDEF000000 + 48'(NF - f); endfunction
    function automatic logic [47:0] tb_smac(input int f); return 48'hBEEFBEEF0000 + 48'(NF - f); endfunction
    function automatic logic [7:0]  tb_pay (input int f); return 8'hDD - 8'(17 * f);            endfunction

    function automatic byte_q_t make_frame(input int fl, input int len);
        byte_q_t q;
        logic [111:0] hdr;
        hdr = {tb_dmac(fl), tb_smac(fl), 16'h0800};
        for (int k = 0; k < len; k++) q.push_back(k < 14 ? hdr[111-8*k -: 8] : tb_pay(fl));
        return q;
    endfunction

    function automatic res_t model(input byte_q_t f);
        res_t r;
        int n;
        logic [47:0] d, s;
        logic [15:0] et;
        bit bad;
        n = f.size();
        r = '0; d = '0; s = '0; et = '0;
        r.len = (n > 2047) ? 11'd2047 : 11'(n);
        if (n >= 14) begin
            for (int k = 0; k < 6; k++) begin
                d = {d[39:0], f[k]};
                s = {s[39:0], f[6+k]};
            end
            et = {f[12], f[13]};
            for (int i = 0; i < NF; i++)
                if (!r.match && d == tb_dmac(i) && s == tb_smac(i) && et == 16'h0800) begin
                    r.match = 1'b1;
                    r.flow  = FW'(i);
                end
        end
        bad = 0;
        for (int k = 14; k < n; k++) if (f[k] != tb_pay(int'(r.flow))) bad = 1;
        r.ok = r.match && !bad && (n == FRAME_SIZE);
        return r;
    endfunction

    task automatic clear_model();
        foreach (mg[i]) begin mg[i] = 0; me[i] = 0; mb[i] = 0; end
        mu = 0;
    endtask

    // Drives a frame one beat per cycle (optional idle cycles), returns cycle of tlast acceptance.
    task automatic send_frame(input byte_q_t f, input int gap_pct, output int unsigned last_cyc);
        int n  = f.size();
        int nb = (n + NB - 1) / NB;
        for (int b = 0; b < nb; b++) begin
            int t = 0;
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                s_axis.tvalid = 1'b0;
                @(posedge clk); #1;
            end
            for (int j = 0; j < NB; j++) begin
                int idx = b * NB + j;
                s_axis.tdata[8*j +: 8] = (idx < n) ? f[idx] : 8'($urandom);
                s_axis.tkeep[j]        = (idx < n);
            end
            s_axis.tlast  = (b == nb - 1);
            s_axis.tvalid = 1'b1;
            while (!s_axis.tready && t < 20) begin @(posedge clk); #1; t++; end
            if (!s_axis.tready) begin
                vectors++; errors++;
                $display("FAIL tready_timeout got %0b exp 1", s_axis.tready);
            end
            @(posedge clk); #1;
        end
        last_cyc      = cyc;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic send_and_expect(input byte_q_t f, input int gap_pct);
        res_t e;
        int unsigned c;
        e = model(f);
        send_frame(f, gap_pct, c);
        e.cyc = c;
        exp_q.push_back(e);
        if (e.match) begin
            if (e.ok) mg[e.flow]++; else me[e.flow]++;
            mb[e.flow] += e.len;
        end else mu++;
    endtask

    task automatic test_reset();
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0;
        rst = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);
        vectors++;
        if ({s_axis.tready, result_valid, result_match, result_ok, result_flow, result_len} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0",
                     {s_axis.tready, result_valid, result_match, result_ok, result_flow, result_len});
        end
        vectors++;
        if ({stat_good, stat_err, stat_unmatched} !== '0) begin
            errors++; $display("FAIL reset_counters got %h exp 0", {stat_good, stat_err, stat_unmatched});
        end
        @(posedge clk); #1; rst = 1'b0;
        vectors++;
        if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL tready_early got %b exp 0", s_axis.tready); end
        @(posedge clk); #1;
        vectors++;
        if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL tready_after_reset got %b exp 1", s_axis.tready); end
    endtask

    // Directed frames from the test plan, one result each.
    task automatic test_directed(input string name, input byte_q_t f);
        logic [32*NF-1:0] eg, ee;
        got_q.delete(); exp_q.delete();
        send_and_expect(f, 0);
        repeat (2) @(posedge clk); #1;
        vectors++;
        if (got_q.size() != 1) begin errors++; $display("FAIL %s count got %0d exp 1", name, got_q.size()); end
        if (got_q.size() > 0) begin
            vectors++;
            if (got_q[0] !== exp_q[0]) begin
                errors++; $display("FAIL %s result got %h exp %h", name, got_q[0], exp_q[0]);
            end
        end
        for (int i = 0; i < NF; i++) begin eg[32*i +: 32] = mg[i]; ee[32*i +: 32] = me[i]; end
        vectors++;
        if ({stat_good, stat_err, stat_unmatched} !== {eg, ee, mu}) begin
            errors++; $display("FAIL %s stats got %h exp %h", name, {stat_good, stat_err, stat_unmatched}, {eg, ee, mu});
        end
    endtask

    task automatic test_back_to_back();
        logic [32*NF-1:0] eg, ee;
        got_q.delete(); exp_q.delete();
        for (int fl = 0; fl < NF; fl++) send_and_expect(make_frame(fl, FRAME_SIZE), 0);
        repeat (2) @(posedge clk); #1;
        vectors++;
        if (got_q.size() != NF) begin errors++; $display("FAIL b2b count got %0d exp %0d", got_q.size(), NF); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            vectors++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b res%0d got %h exp %h", k, got_q[k], exp_q[k]); end
            if (k > 0) begin
                vectors++;
                if (got_q[k].cyc - got_q[k-1].cyc != 3) begin
                    errors++; $display("FAIL b2b spacing%0d got %0d exp 3", k, got_q[k].cyc - got_q[k-1].cyc);
                end
            end
        end
        for (int i = 0; i < NF; i++) begin eg[32*i +: 32] = mg[i]; ee[32*i +: 32] = me[i]; end
        vectors++;
        if ({stat_good, stat_err, stat_unmatched} !== {eg, ee, mu}) begin
            errors++; $display("FAIL b2b stats got %h exp %h", {stat_good, stat_err, stat_unmatched}, {eg, ee, mu});
        end
    endtask

    task automatic test_mid_reset();
        byte_q_t f;
        logic [32*NF-1:0] eg, ee;
        got_q.delete(); exp_q.delete();
        f = make_frame(1, FRAME_SIZE);
        for (int j = 0; j < NB; j++) begin s_axis.tdata[8*j +: 8] = f[j]; s_axis.tkeep[j] = 1'b1; end
        s_axis.tlast = 1'b0; s_axis.tvalid = 1'b1;
        @(posedge clk); #1;
        s_axis.tvalid = 1'b0; rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        send_and_expect(make_frame(2, FRAME_SIZE), 0);
        repeat (2) @(posedge clk); #1;
        vectors++;
        if (got_q.size() != 1) begin errors++; $display("FAIL mid_reset count got %0d exp 1", got_q.size()); end
        if (got_q.size() > 0) begin
            vectors++;
            if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL mid_reset result got %h exp %h", got_q[0], exp_q[0]); end
        end
        for (int i = 0; i < NF; i++) begin eg[32*i +: 32] = mg[i]; ee[32*i +: 32] = me[i]; end
        vectors++;
        if ({stat_good, stat_err, stat_unmatched} !== {eg, ee, mu}) begin
            errors++; $display("FAIL mid_reset stats got %h exp %h", {stat_good, stat_err, stat_unmatched}, {eg, ee, mu});
        end
    endtask

    task automatic test_random();
        logic [32*NF-1:0] eg, ee;
        got_q.delete(); exp_q.delete();
        for (int n = 0; n < 40; n++) begin
            int fl, len, p;
            byte_q_t f;
            fl  = $urandom_range(0, NF - 1);
            len = ($urandom_range(0, 9) < 6) ? FRAME_SIZE : $urandom_range(1, 300);
            f   = make_frame(fl, len);
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, f.size() - 1);
                f[p] = f[p] ^ 8'($urandom_range(1, 255));
            end
            send_and_expect(f, $urandom_range(0, 1) ? 30 : 0);
        end
        repeat (2) @(posedge clk); #1;
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            vectors++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL random res%0d got %h exp %h", k, got_q[k], exp_q[k]); end
        end
        for (int i = 0; i < NF; i++) begin eg[32*i +: 32] = mg[i]; ee[32*i +: 32] = me[i]; end
        vectors++;
        if ({stat_good, stat_err, stat_unmatched} !== {eg, ee, mu}) begin
            errors++; $display("FAIL random stats got %h exp %h", {stat_good, stat_err, stat_unmatched}, {eg, ee, mu});
        end
`ifdef PACKET_CHECKER_BYTE_COUNT_EN
        for (int i = 0; i < NF; i++) begin
            vectors++;
            if (stat_bytes[64*i +: 64] !== mb[i]) begin
                errors++; $display("FAIL random bytes%0d got %0d exp %0d", i, stat_bytes[64*i +: 64], mb[i]);
            end
        end
`endif
    endtask

    initial begin
        byte_q_t f;
        test_reset();
        test_directed("good_frame", make_frame(0, FRAME_SIZE));
        f = make_frame(0, FRAME_SIZE); f[100] = 8'h00;
        test_directed("payload_err", f);
        test_directed("short_190", make_frame(0, 190));
        f = make_frame(0, FRAME_SIZE);
        for (int k = 0; k < 6; k++) f[k] = 8'h00;
        test_directed("unmatched", f);
        test_directed("runt", make_frame(0, 10));
        test_directed("header_only", make_frame(1, 14));
        test_directed("len_saturate", make_frame(2, 2100));
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/packet_checker.md
Name: packet_checker

Overview:
- AXI-Stream sink that receives Ethernet frames and classifies each one against a table of N_FLOWS expected flows.
- Per frame it checks the destination MAC, source MAC, ethertype, constant payload byte and frame size.
- Keeps per-flow good/error counters and emits a one-cycle result record per frame.
- Sits at the receive end of a link or loopback whose far end is the traffic generator; used for on-chip pass/fail of generated traffic.

Parameters:
- DATA_WIDTH, 512, tdata width in bits; multiple of 8, at least 128, so the 14-byte header always lands in beat 0.
- N_FLOWS, 4, number of expected flows (1..16).
- SIZES, {4{11'd192}}, expected frame length in bytes per flow; flow i occupies bits [11i+10:11i].
- D_MACS, {48'hABCDEF000001..4}, expected destination MAC per flow, 48 bits each.
- S_MACS, {48'hBEEFBEEF0001..4}, expected source MAC per flow, 48 bits each.
- ETHERTYPES, {4{16'h0800}}, expected ethertype per flow, 16 bits each.
- PAYLOADS, {8'hAA,8'hBB,8'hCC,8'hDD}, expected payload byte per flow, 8 bits each.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- s_axis_tdata, in, DATA_WIDTH: frame data; byte k in bits [8k+7:8k], wire byte 0 first.
- s_axis_tkeep, in, DATA_WIDTH/8: byte enables; contiguous from bit 0.
- s_axis_tvalid, in, 1: beat valid.
- s_axis_tready, out, 1: sink ready.
- s_axis_tlast, in, 1: last beat of frame.
- result_valid, out, 1: one-cycle pulse per completed frame.
- result_flow, out, $clog2(N_FLOWS) (min 1): matched flow index; 0 when unmatched.
- result_match, out, 1: header matched a flow.
- result_ok, out, 1: matched, length equal to SIZES, and all payload bytes correct.
- result_len, out, 11: received byte count, saturating at 2047.
- stat_good, out, 32*N_FLOWS: per-flow count of frames with result_ok=1.
- stat_err, out, 32*N_FLOWS: per-flow count of matched frames with result_ok=0.
- stat_unmatched, out, 32: count of frames that matched no flow.

Behaviour:
- Reset: s_axis_tready=0, all result_* outputs 0, all counters 0, FSM in S_HEAD. From the cycle after rst deasserts, tready=1 constantly; the block never backpressures.
- A beat is accepted when tvalid && tready.
- FSM S_HEAD, first beat of a frame:
  - Extract DMAC = bytes 0..5 (byte 0 is the MSB), SMAC = bytes 6..11, ethertype = bytes 12..13 (byte 12 is the MSB).
  - Flow select: lowest index i whose DMAC, SMAC and ethertype all equal table entry i. Register the match flag and index.
  - Payload check: every kept byte at index 14 or higher must equal PAYLOADS[i].
  - Length: len = popcount(tkeep).
  - If tlast=0, go to S_BODY.
- FSM S_BODY: every kept byte is payload and is checked against the latched flow's byte; len += popcount(tkeep), saturating at 2047. On tlast, return to S_HEAD.
- Runt frame (tlast on beat 0 with fewer than 14 kept bytes): treated as unmatched.
- Result timing: result_* registered and valid exactly 1 cycle after the tlast beat is accepted. The appropriate counter increments on that same edge. Back-to-back frames are supported: a new frame may begin the cycle after tlast.
- Payload errors: a mismatch sticky flag clears at each S_HEAD.
- Counters saturate at 32'hFFFFFFFF.
- tvalid=0 mid-frame: state is held; no timeout.
- rst mid-frame: partial frame discarded, no result, counters cleared.

Optional Feature:
- Macro: PACKET_CHECKER_BYTE_COUNT_EN.
- When defined: adds output stat_bytes, 64*N_FLOWS, a per-flow accumulator of result_len over matched frames (good and error), updated on the same edge as the packet counters, wrapping at 2^64.
- When undefined: the port and its logic are absent.

Decomposition:
- Package packet_checker_pkg: HDR_BYTES=14, LEN_W=11, CNT_W=32, FSM state typedef {S_HEAD, S_BODY}, function popcount_keep.
- One sub-module, flow_counter: a saturating CNT_W counter with increment enable and rst. Instantiated 2*N_FLOWS+1 times.

Test Plan:
- Single 192-byte frame for flow 0: DMAC ABCDEF000004, SMAC BEEFBEEF0004, 0800, payload DD, as 3 full 64-byte beats -> result_valid 1 cycle after the third beat, flow=0, match=1, ok=1, len=192; stat_good[31:0]=1.
- Same header, but byte 100 = 8'h00 -> ok=0, len=192; stat_err[flow0]=1, stat_good unchanged.
- 190-byte frame (last beat tkeep = 62 ones) -> len=190, ok=0.
- DMAC 000000000000 -> match=0, flow=0; stat_unmatched=1.
- 4 frames back-to-back, one per flow, tvalid held high, no gaps -> 4 result pulses 3 cycles apart; each stat_good entry = 1.
- rst pulsed after beat 1 of a frame, then a full valid frame -> exactly one result; counters reflect only the second frame.
